// File: rtl/dsk_pkg.sv
// Shared types and widths for the disk-image fetch path.
package dsk_pkg;
  localparam int DSK_ADDR_W = 22;
  localparam int DSK_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dsk_state_e;
endpackage

// File: rtl/dsk_word_fifo.sv
// Word FIFO between memory capture and the byte serializer; head is readable without popping.
module dsk_word_fifo
  import dsk_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        _reset,
  input  logic                        i_flush,
  input  logic                        i_push,
  input  logic [DSK_DATA_W-1:0]       i_wr_data,
  input  logic                        i_pop,
  output logic [DSK_DATA_W-1:0]       o_rd_data,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [$clog2(FIFO_DEPTH):0] o_level
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DSK_DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic                  w_do_push;
  logic                  w_do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_level   = r_wr_ptr - r_rd_ptr;
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!_reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end
endmodule

// File: rtl/dsk_fetch_engine.sv
// Burst reader for one drive: captures granted memory words and streams them out high byte first.
module dsk_fetch_engine
  import dsk_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 12
) (
  input  logic                  clk,
  input  logic                  _reset,
  input  logic                  dskReadAck,
  input  logic                  memoryLatch,
  input  logic [DSK_DATA_W-1:0] memoryDataIn,
  output logic [DSK_ADDR_W-1:0] dskReadAddr,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DSK_ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]      req_words,
  input  logic                  abort,
  output logic                  byte_valid,
  output logic [7:0]            byte_data,
  input  logic                  byte_ready,
  output logic                  busy,
  output logic                  done
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  dsk_state_e            r_state;
  dsk_state_e            w_state_nxt;
  logic [DSK_ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]      r_remaining;
  logic                  r_byte_valid;
  logic [7:0]            r_byte_data;
  logic [7:0]            r_lo_byte;
  logic                  r_hi_shown;

  logic                  w_accept;
  logic                  w_room;
  logic                  w_capture;
  logic                  w_byte_take;
  logic                  w_ser_load;
  logic [DSK_DATA_W-1:0] w_head;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [LVL_W-1:0]      w_fifo_level;

  // The serializer's word counts against FIFO_DEPTH so total buffering stays at FIFO_DEPTH words.
  assign w_room      = !w_fifo_full && !((w_fifo_level == LVL_W'(FIFO_DEPTH - 1)) && r_byte_valid);
  assign w_accept    = req_valid && (r_state == IDLE) && !abort;
  assign w_capture   = (r_state == FETCH) && dskReadAck && memoryLatch && w_room && !abort;
  assign w_byte_take = r_byte_valid && byte_ready;
  assign w_ser_load  = !w_fifo_empty && (!r_byte_valid || (w_byte_take && !r_hi_shown));

  assign dskReadAddr = r_addr;
  assign req_ready   = (r_state == IDLE);
  assign busy        = (r_state == FETCH) || (r_state == DRAIN);
  assign done        = (r_state == DONE);
  assign byte_valid  = r_byte_valid;
  assign byte_data   = r_byte_data;

  always_ff @(posedge clk) begin
    if (!_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_state_nxt = (req_words == '0) ? DONE : FETCH;
        FETCH:   if (w_capture && (r_remaining == LEN_W'(1))) w_state_nxt = DRAIN;
        DRAIN:   if (w_fifo_empty && !r_byte_valid) w_state_nxt = DONE;
        DONE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Capture stage: address only moves on a capture edge, so it is stable through each ack window.
  always_ff @(posedge clk) begin
    if (!_reset) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (w_accept && (req_words != '0)) begin
      r_addr      <= req_addr;
      r_remaining <= req_words;
    end else if (w_capture) begin
      r_addr      <= r_addr + 1'b1;
      r_remaining <= r_remaining - 1'b1;
    end
  end

  dsk_word_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    ._reset   (_reset),
    .i_flush  (abort),
    .i_push   (w_capture),
    .i_wr_data(memoryDataIn),
    .i_pop    (w_ser_load && !abort),
    .o_rd_data(w_head),
    .o_full   (w_fifo_full),
    .o_empty  (w_fifo_empty),
    .o_level  (w_fifo_level)
  );

  // Serializer stage: a new word loads on the same edge its predecessor's low byte is taken.
  always_ff @(posedge clk) begin
    if (!_reset) begin
      r_byte_valid <= 1'b0;
      r_byte_data  <= '0;
      r_lo_byte    <= '0;
      r_hi_shown   <= 1'b0;
    end else if (abort) begin
      r_byte_valid <= 1'b0;
      r_hi_shown   <= 1'b0;
    end else if (w_ser_load) begin
      r_byte_valid <= 1'b1;
      r_byte_data  <= w_head[15:8];
      r_lo_byte    <= w_head[7:0];
      r_hi_shown   <= 1'b1;
    end else if (w_byte_take) begin
      if (r_hi_shown) begin
        r_byte_data <= r_lo_byte;
        r_hi_shown  <= 1'b0;
      end else begin
        r_byte_valid <= 1'b0;
      end
    end
  end
endmodule
